dmi_arbiter: RTL and testbench

DMI_ARBITER -- requirements
Module: dmi_arbiter

---
 rtl/dmi_arbiter_pkg.sv | 19 +
 rtl/dmi_arbiter_rr_arb2.sv | 16 +
 rtl/dmi_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dmi_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_arbiter_pkg.sv
// rtl/dmi_arbiter_pkg.sv - shared FSM state, DMI op and response encodings
package dmi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_RESP_OK   = 2'd0;
    localparam logic [1:0] DMI_RESP_FAIL = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY = 2'd3;

endpackage

// File: rtl/dmi_arbiter_rr_arb2.sv
// rtl/dmi_arbiter_rr_arb2.sv - two-way round-robin grant (one-hot gnt)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On contention the requester that did not win last time is granted.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// rtl/dmi_arbiter.sv - two-requester DMI arbiter; optional response timeout under DMI_ARB_TIMEOUT_EN
module dmi_arbiter
    import dmi_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              resetn,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [31:0]       m0_req_data,
    input  logic [1:0]        m0_req_op,
    output logic              m0_resp_valid,
    input  logic              m0_resp_ready,
    output logic [31:0]       m0_resp_data,
    output logic [1:0]        m0_resp_resp,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [31:0]       m1_req_data,
    input  logic [1:0]        m1_req_op,
    output logic              m1_resp_valid,
    input  logic              m1_resp_ready,
    output logic [31:0]       m1_resp_data,
    output logic [1:0]        m1_resp_resp,

    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic [ADDR_W-1:0] s_req_addr,
    output logic [31:0]       s_req_data,
    output logic [1:0]        s_req_op,
    input  logic              s_resp_valid,
    output logic              s_resp_ready,
    input  logic [31:0]       s_resp_data,
    input  logic [1:0]        s_resp_resp,

    output logic              busy,
    output logic              grant_id
);

    state_t              state;
    state_t              state_nxt;
    logic                last_grant;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic [1:0]          op_q;
    logic [1:0]          gnt;
    logic                drain;
    logic                tmo_hit;
    logic                sel_ready;
    logic                accept;
    logic                resp_done;
    logic                resp_valid_sel;
    logic [31:0]         resp_data_sel;
    logic [1:0]          resp_resp_sel;

    // A pending drain blocks new grants until the stale response is swallowed.
    rr_arb2 u_rr_arb2 (
        .req  ({m1_req_valid, m0_req_valid} & {2{~drain}}),
        .last (last_grant),
        .gnt  (gnt)
    );

    assign sel_ready = grant_id ? m1_resp_ready : m0_resp_ready;
    assign accept    = (state == ST_IDLE) && (|gnt);

    always_comb begin
        state_nxt      = state;
        m0_req_ready   = 1'b0;
        m1_req_ready   = 1'b0;
        s_resp_ready   = drain;
        resp_valid_sel = 1'b0;
        resp_data_sel  = 32'd0;
        resp_resp_sel  = DMI_RESP_OK;
        resp_done      = 1'b0;
        case (state)
            ST_IDLE: begin
                m0_req_ready = gnt[0] & resetn;
                m1_req_ready = gnt[1] & resetn;
                if (|gnt) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (s_req_ready) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid_sel = s_resp_valid;
                resp_data_sel  = s_resp_data;
                resp_resp_sel  = s_resp_resp;
                s_resp_ready   = sel_ready;
                if (s_resp_valid && sel_ready) begin
                    state_nxt = ST_IDLE;
                    resp_done = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = ST_ERR;
                end
            end
`ifdef DMI_ARB_TIMEOUT_EN
            ST_ERR: begin
                resp_valid_sel = 1'b1;
                resp_resp_sel  = DMI_RESP_FAIL;
                if (sel_ready) begin
                    state_nxt = ST_IDLE;
                    resp_done = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign m0_resp_valid = resp_valid_sel & ~grant_id;
    assign m1_resp_valid = resp_valid_sel &  grant_id;
    assign m0_resp_data  = grant_id ? 32'd0 : resp_data_sel;
    assign m1_resp_data  = grant_id ? resp_data_sel : 32'd0;
    assign m0_resp_resp  = grant_id ? 2'd0 : resp_resp_sel;
    assign m1_resp_resp  = grant_id ? resp_resp_sel : 2'd0;

    assign s_req_valid = (state == ST_REQ);
    assign s_req_addr  = addr_q;
    assign s_req_data  = data_q;
    assign s_req_op    = op_q;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            addr_q     <= '0;
            data_q     <= 32'd0;
            op_q       <= DMI_OP_NOP;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant_id <= gnt[1];
                addr_q   <= gnt[1] ? m1_req_addr : m0_req_addr;
                data_q   <= gnt[1] ? m1_req_data : m0_req_data;
                op_q     <= gnt[1] ? m1_req_op   : m0_req_op;
            end
            if (resp_done) begin
                last_grant <= grant_id;
            end
        end
    end

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts only cycles in RESP with no target response offered.
    assign tmo_hit = (state == ST_RESP) && !s_resp_valid &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
            drain   <= 1'b0;
        end else begin
            if (state != ST_RESP) begin
                tmo_cnt <= '0;
            end else if (!s_resp_valid) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (state == ST_ERR && sel_ready) begin
                drain <= 1'b1;
            end else if (drain && s_resp_valid) begin
                drain <= 1'b0;
            end
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign drain      = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb/tb_dmi_arbiter.sv - randomized self-checking bench for dmi_arbiter
module tb_dmi_arbiter;

    localparam int AW = 7;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          m0_req_valid = 0, m0_req_ready, m0_resp_valid, m0_resp_ready = 0;
    logic [AW-1:0] m0_req_addr = '0;
    logic [31:0]   m0_req_data = '0, m0_resp_data;
    logic [1:0]    m0_req_op = '0, m0_resp_resp;
    logic          m1_req_valid = 0, m1_req_ready, m1_resp_valid, m1_resp_ready = 0;
    logic [AW-1:0] m1_req_addr = '0;
    logic [31:0]   m1_req_data = '0, m1_resp_data;
    logic [1:0]    m1_req_op = '0, m1_resp_resp;
    logic          s_req_valid, s_req_ready = 0, s_resp_valid = 0, s_resp_ready;
    logic [AW-1:0] s_req_addr;
    logic [31:0]   s_req_data, s_resp_data = '0;
    logic [1:0]    s_req_op, s_resp_resp = '0;
    logic          busy, grant_id;

    int n_checks = 0;
    int n_pass   = 0;
    int model_last = 1;

    always #5 clock = ~clock;

    dmi_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .resetn(resetn),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_req_data(m0_req_data), .m0_req_op(m0_req_op), .m0_resp_valid(m0_resp_valid),
        .m0_resp_ready(m0_resp_ready), .m0_resp_data(m0_resp_data), .m0_resp_resp(m0_resp_resp),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_data(m1_req_data), .m1_req_op(m1_req_op), .m1_resp_valid(m1_resp_valid),
        .m1_resp_ready(m1_resp_ready), .m1_resp_data(m1_resp_data), .m1_resp_resp(m1_resp_resp),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_data(s_req_data), .s_req_op(s_req_op), .s_resp_valid(s_resp_valid),
        .s_resp_ready(s_resp_ready), .s_resp_data(s_resp_data), .s_resp_resp(s_resp_resp),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference arbitration: sole requester wins; on contention the one not served last.
    function automatic int pick(input bit v0, input bit v1);
        if (v0 && v1) return (model_last == 1) ? 0 : 1;
        return v1 ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic txn(input bit v0, input bit v1, input int req_stall, input int resp_stall,
                       input int mr_stall, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] o0,
                       input logic [1:0] o1, input logic [31:0] rd, input logic [1:0] rr);
        int w;
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        logic [1:0]    eo;
        w  = pick(v0, v1);
        ea = (w == 1) ? a1 : a0;
        ed = (w == 1) ? d1 : d0;
        eo = (w == 1) ? o1 : o0;
        m0_req_valid = v0; m0_req_addr = a0; m0_req_data = d0; m0_req_op = o0;
        m1_req_valid = v1; m1_req_addr = a1; m1_req_data = d1; m1_req_op = o1;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_m0_ready", m0_req_ready, w == 0);
        chk("idle_m1_ready", m1_req_ready, w == 1);
        chk("idle_s_req_valid", s_req_valid, 0);
        tick();
        m0_req_valid = 0; m1_req_valid = 0;
        #1;
        chk("req_first_valid", s_req_valid, 1);
        chk("grant_id", grant_id, w);
        chk("req_busy", busy, 1);
        for (int i = 0; i < req_stall; i++) begin
            m0_req_valid = 1; m1_req_valid = 1; s_resp_valid = 1;
            #1;
            chk("stall_valid", s_req_valid, 1);
            chk("stall_addr", s_req_addr, ea);
            chk("stall_data", s_req_data, ed);
            chk("stall_op", s_req_op, eo);
            chk("stall_m0_ready", m0_req_ready, 0);
            chk("stall_m1_ready", m1_req_ready, 0);
            chk("stray_resp_ready", s_resp_ready, 0);
            tick();
        end
        m0_req_valid = 0; m1_req_valid = 0; s_resp_valid = 0;
        s_req_ready = 1;
        #1;
        chk("req_addr", s_req_addr, ea);
        chk("req_data", s_req_data, ed);
        chk("req_op", s_req_op, eo);
        tick();
        s_req_ready = 0;
        #1;
        chk("resp_no_req_valid", s_req_valid, 0);
        for (int i = 0; i < resp_stall; i++) begin
            chk("wait_m0_rv", m0_resp_valid, 0);
            chk("wait_m1_rv", m1_resp_valid, 0);
            tick();
        end
        s_resp_valid = 1; s_resp_data = rd; s_resp_resp = rr;
        for (int i = 0; i < mr_stall; i++) begin
            #1;
            chk("rv_win", (w == 0) ? m0_resp_valid : m1_resp_valid, 1);
            chk("rv_lose", (w == 0) ? m1_resp_valid : m0_resp_valid, 0);
            chk("s_resp_ready_hold", s_resp_ready, 0);
            tick();
        end
        if (w == 0) m0_resp_ready = 1; else m1_resp_ready = 1;
        if (w == 0) m1_req_valid = 1; else m0_req_valid = 1;
        #1;
        chk("s_resp_ready", s_resp_ready, 1);
        chk("resp_data", (w == 0) ? m0_resp_data : m1_resp_data, rd);
        chk("resp_resp", (w == 0) ? m0_resp_resp : m1_resp_resp, rr);
        chk("no_grant_in_resp", (w == 0) ? m1_req_ready : m0_req_ready, 0);
        tick();
        s_resp_valid = 0; m0_resp_ready = 0; m1_resp_ready = 0;
        m0_req_valid = 0; m1_req_valid = 0;
        model_last = w;
        #1;
        chk("done_busy", busy, 0);
    endtask

    task automatic rnd_txn(input bit v0, input bit v1, input int rs);
        txn(v0, v1, rs, $urandom_range(0, 3), $urandom_range(0, 2),
            AW'($urandom), AW'($urandom), $urandom, $urandom,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)));
    endtask

    initial begin
        int v;
        @(negedge clock);
        m0_req_valid = 1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_s_req_valid", s_req_valid, 0);
        chk("rst_m0_req_ready", m0_req_ready, 0);
        chk("rst_payload", {s_req_addr, s_req_data, s_req_op}, 0);
        chk("rst_s_resp_ready", s_resp_ready, 0);
        m0_req_valid = 0;
        tick();
        resetn = 1;
        @(negedge clock);

        for (int i = 0; i < 4; i++) begin
            chk("alt_expect", pick(1, 1), i % 2);
            rnd_txn(1, 1, 0);
        end

        txn(1, 0, 0, 0, 0, 7'h11, 7'h00, 32'h0, 32'h0, 2'd1, 2'd0, 32'hDEADBEEF, 2'd0);
        txn(1, 1, 5, 1, 1, 7'h22, 7'h33, 32'h12345678, 32'h9, 2'd2, 2'd1, 32'h55AA55AA, 2'd3);

        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(1, 3);
            rnd_txn(v[0], v[1], $urandom_range(0, 3));
        end

        // Reset while a response is pending.
        m1_req_valid = 1;
        tick();
        m1_req_valid = 0;
        s_req_ready = 1;
        tick();
        s_req_ready = 0;
        #1;
        chk("pre_rst_busy", busy, 1);
        #2;
        resetn = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_s_req_valid", s_req_valid, 0);
        chk("midrst_grant_id", grant_id, 0);
        model_last = 1;
        @(negedge clock);
        resetn = 1;
        rnd_txn(1, 1, 1);

`ifdef DMI_ARB_TIMEOUT_EN
        m0_req_valid = 1;
        tick();
        m0_req_valid = 0;
        s_req_ready = 1;
        tick();
        s_req_ready = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("tmo_wait", m0_resp_valid, 0);
            tick();
        end
        #1;
        chk("tmo_err_valid", m0_resp_valid, 1);
        chk("tmo_err_resp", m0_resp_resp, 2);
        chk("tmo_err_data", m0_resp_data, 0);
        m0_resp_ready = 1;
        tick();
        m0_resp_ready = 0;
        model_last = 0;
        m1_req_valid = 1;
        #1;
        chk("drain_no_grant", m1_req_ready, 0);
        chk("drain_s_ready", s_resp_ready, 1);
        s_resp_valid = 1; s_resp_data = 32'hBAD0BAD0;
        #1;
        chk("drain_no_fwd", m1_resp_valid | m0_resp_valid, 0);
        tick();
        s_resp_valid = 0;
        m1_req_valid = 0;
        #1;
        chk("drain_cleared", s_resp_ready, 0);
        rnd_txn(0, 1, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
